issue_queue_ctrl: RTL

- Sits between `decode` and the issue/execute register. It buffers decoded instruction pairs in a small in-order FIFO and decides each cycle whether to issue 0, 1 or 2 instructions.
- Issue is constrained by intra-pair RAW hazards, the single memory port, branch/delay-slot pairing, serializing ops and load-use against the previously issued group.
- Outputs go through a registered issue stage that feeds execute.

---
 rtl/issue_queue_ctrl_pkg.sv | 63 ++++++
 rtl/issue_queue_ctrl_iq_fifo.sv | 77 +++++++
 rtl/issue_queue_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/issue_queue_ctrl_pkg.sv
// Shared types and helpers for the issue queue controller.
// Defines the decoded-instruction record that decode hands over, the 0/1/2 issue
// count type, and small predicates used by the hazard selection logic.
package issue_queue_ctrl_pkg;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic [2:0] cp0_ctl;
    logic [2:0] cache_ctl;
  } ctl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  rdst;
    ctl_t        ctl;
  } decode_data_t;

  typedef logic [1:0] issue_count_t;

  localparam issue_count_t ISSUE_NONE = 2'd0;
  localparam issue_count_t ISSUE_ONE  = 2'd1;
  localparam issue_count_t ISSUE_TWO  = 2'd2;

  function automatic logic is_mem(input ctl_t c);
    return c.memtoreg | c.memwrite;
  endfunction

  function automatic logic is_bj(input ctl_t c);
    return c.branch | c.jump;
  endfunction

  // Ops that must not share an issue group with anything else.
  function automatic logic is_serial(input ctl_t c);
    return (c.cp0_ctl != 3'd0) || (c.cache_ctl != 3'd0);
  endfunction

  // r0 is hardwired zero, so a dependency on it is never a hazard.
  function automatic logic reads(input decode_data_t d, input logic [4:0] r);
    return (r != 5'd0) && ((d.ra1 == r) || (d.ra2 == r));
  endfunction

  // True when d consumes the result of a load sitting in the issue register.
  function automatic logic load_use(input decode_data_t d, input decode_data_t [1:0] iss);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (iss[i].valid && iss[i].ctl.memtoreg && reads(d, iss[i].rdst)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/issue_queue_ctrl_iq_fifo.sv
// In-order instruction FIFO with 0-2 pushes and 0-2 pops per cycle.
// Ports: push_cnt/push_a/push_b (push_a is the older entry), pop_cnt,
// flush (empties the queue), h0/h1 (head and head+1, zero when not covered by
// count), count (occupancy) and ready (room for a full pair).
module issue_queue_ctrl_iq_fifo
  import issue_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  issue_count_t           push_cnt,
  input  decode_data_t           push_a,
  input  decode_data_t           push_b,
  input  issue_count_t           pop_cnt,
  output decode_data_t           h0,
  output decode_data_t           h1,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decode_data_t    mem_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;

  // Entry storage; only ever holds valid entries, stale ones are masked by count.
  always_ff @(posedge clk) begin
    if (push_cnt != ISSUE_NONE) begin
      mem_r[tail_r] <= push_a;
    end
    if (push_cnt == ISSUE_TWO) begin
      mem_r[tail_r + PW'(1)] <= push_b;
    end
  end

  // Pointers and occupancy; power-of-two depth makes the wrap implicit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PW'(pop_cnt);
      tail_r  <= tail_r + PW'(push_cnt);
      count_r <= count_r + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  // Head candidates, zeroed when the queue does not cover them.
  always_comb begin
    h0 = '0;
    h1 = '0;
    if (count_r != '0) begin
      h0 = mem_r[head_r];
    end else begin
      h0 = '0;
    end
    if (count_r >= CW'(2)) begin
      h1 = mem_r[head_r + PW'(1)];
    end else begin
      h1 = '0;
    end
  end

  assign count = count_r;
  assign ready = (count_r <= CW'(DEPTH - 2));

endmodule

// File: rtl/issue_queue_ctrl.sv
// Dual-issue queue controller between decode and execute.
// Ports: clk, resetn (async active-low), dataD (decoded pair, [1] older),
// ready (queue can take a pair), stall (freezes issue register, blocks pops),
// flush (clears queue and issue register), dataI (registered issue group,
// [1] older), count (queue occupancy).
module issue_queue_ctrl
  import issue_queue_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  decode_data_t [1:0]     dataD,
  output logic                   ready,
  input  logic                   stall,
  input  logic                   flush,
  output decode_data_t [1:0]     dataI,
  output logic [$clog2(DEPTH):0] count
);

  decode_data_t       push_a_s;
  decode_data_t       push_b_s;
  decode_data_t       h0_s;
  decode_data_t       h1_s;
  issue_count_t       raw_push_s;
  issue_count_t       push_cnt_s;
  issue_count_t       issue_cnt_s;
  issue_count_t       pop_cnt_s;
  decode_data_t [1:0] issue_r;
  logic               lu0_s;
  logic               lu1_s;
  logic               split_s;

  // Compact the decoded pair so the older valid entry is always pushed first.
  always_comb begin
    push_a_s   = '0;
    push_b_s   = '0;
    raw_push_s = ISSUE_NONE;
    if (dataD[1].valid) begin
      push_a_s   = dataD[1];
      push_b_s   = dataD[0];
      raw_push_s = dataD[0].valid ? ISSUE_TWO : ISSUE_ONE;
    end else if (dataD[0].valid) begin
      push_a_s   = dataD[0];
      raw_push_s = ISSUE_ONE;
    end else begin
      raw_push_s = ISSUE_NONE;
    end
  end

  assign push_cnt_s = (ready && !flush) ? raw_push_s : ISSUE_NONE;
  assign pop_cnt_s  = (stall || flush) ? ISSUE_NONE : issue_cnt_s;

  issue_queue_ctrl_iq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .push_cnt (push_cnt_s),
    .push_a   (push_a_s),
    .push_b   (push_b_s),
    .pop_cnt  (pop_cnt_s),
    .h0       (h0_s),
    .h1       (h1_s),
    .count    (count),
    .ready    (ready)
  );

  // Hazard checks and the 0/1/2 issue decision for the head pair.
  always_comb begin
    lu0_s   = load_use(h0_s, issue_r);
    lu1_s   = h1_s.valid && load_use(h1_s, issue_r);
    split_s = !h1_s.valid
           || is_bj(h1_s.ctl)
           || (h0_s.ctl.regwrite && reads(h1_s, h0_s.rdst))
           || (is_mem(h0_s.ctl) && is_mem(h1_s.ctl))
           || is_serial(h0_s.ctl) || is_serial(h1_s.ctl)
           || lu1_s;
    issue_cnt_s = ISSUE_NONE;
    if (!h0_s.valid) begin
      issue_cnt_s = ISSUE_NONE;
    end else if (is_bj(h0_s.ctl)) begin
      // A branch only leaves together with its delay slot.
      issue_cnt_s = (h1_s.valid && !lu0_s && !lu1_s) ? ISSUE_TWO : ISSUE_NONE;
    end else if (lu0_s) begin
      issue_cnt_s = ISSUE_NONE;
    end else if (split_s) begin
      issue_cnt_s = ISSUE_ONE;
    end else begin
      issue_cnt_s = ISSUE_TWO;
    end
  end

  // Issue register; unused slots are fully zeroed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      issue_r <= '0;
    end else if (flush) begin
      issue_r <= '0;
    end else if (!stall) begin
      issue_r[1] <= (issue_cnt_s != ISSUE_NONE) ? h0_s : '0;
      issue_r[0] <= (issue_cnt_s == ISSUE_TWO) ? h1_s : '0;
    end else begin
      issue_r <= issue_r;
    end
  end

  assign dataI = issue_r;

endmodule
